rect_fill: RTL and testbench
============================

RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter H_RES, default 640; horizontal pixel count.
REQ-002 Parameter V_RES, default 480; vertical pixel count.
REQ-003 Parameter XW, default 10; x coordinate width, SHALL satisfy 2**XW >= H_RES.
REQ-004 Parameter YW, default 9; y coordinate width, SHALL satisfy 2**YW >= V_RES.
REQ-005 Parameter CW, default 1; pixel colour width.
REQ-006 clk  in  1  single clock; all state changes on posedge clk.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request; sampled only in IDLE.
REQ-009 x0, x1  in  XW  inclusive column bounds; captured on the accepted start.
REQ-010 y0, y1  in  YW  inclusive row bounds; captured on the accepted start.
REQ-011 fill_color  in  CW  colour; captured on the accepted start.
REQ-012 wr_ready  in  1  sink accepts the current pixel this cycle.
REQ-013 x  out  XW  current pixel column.
REQ-014 y  out  YW  current pixel row.
REQ-015 color  out  CW  current pixel colour.
REQ-016 wr_en  out  1  x/y/color valid.
REQ-017 busy  out  1  high in FILL.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, FILL, DONE; reset enters IDLE.
REQ-020 IDLE: start=1 SHALL capture bounds and colour and go to FILL; start=0 keeps IDLE.
REQ-021 Captured x1 SHALL be clamped to H_RES-1 and y1 to V_RES-1; x0/y0 likewise.
REQ-022 Empty region (x0>x1 or y0>y1 after clamp): IDLE SHALL go directly to DONE with zero writes.
REQ-023 First wr_en SHALL assert the cycle after start, with x=x0, y=y0.
REQ-024 Traversal SHALL be column-major: y increments inner from y0 to y1, then y returns to y0 and x increments.
REQ-025 A pixel is accepted when wr_en and wr_ready are both high; only then SHALL x/y advance.
REQ-026 wr_en high with wr_ready low SHALL hold x, y and color stable (no drop, no repeat).
REQ-027 Accept at (x1,y1) SHALL move FILL to DONE; wr_en SHALL deassert in that next cycle.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 Total accepted writes SHALL equal (x1-x0+1)*(y1-y0+1) after clamp.
REQ-030 start during FILL or DONE SHALL be ignored.
REQ-031 Counters SHALL never exceed x1/y1; no wrap past H_RES-1 or V_RES-1.

Reset
REQ-032 Asserting reset at any time, including mid-fill, SHALL immediately force IDLE, x=0, y=0, color=0, wr_en=0, busy=0, done=0.
REQ-033 After reset deassertion the block SHALL accept start on the first clock edge.

Structure
REQ-034 Package fill_pkg SHALL hold the state enum and the default resolution constants (640, 480, XW=10, YW=9).
REQ-035 Sub-module span_counter SHALL provide a loadable up-counter with enable and a terminal flag (count==limit).
REQ-036 rect_fill SHALL instantiate span_counter twice, once for x and once for y.

Verification
REQ-037 H_RES=6, V_RES=4; full-screen start (0,0)-(5,3), wr_ready=1 -> 24 writes in column-major order; done one cycle after the (5,3) accept.
REQ-038 Region (2,1)-(3,2), colour 1 -> writes (2,1),(2,2),(3,1),(3,2); busy high for 4 cycles.
REQ-039 wr_ready low for 3 cycles at pixel (2,2) -> x/y/color held; count still 4; done delayed 3 cycles.
REQ-040 Region x0=4, x1=2 -> no wr_en; done pulses the cycle after start.
REQ-041 Reset asserted asynchronously mid-fill -> outputs zero before the next edge; a new start succeeds.
REQ-042 start pulsed during FILL, and x1=9 with H_RES=6 -> restart ignored; x clamps at 5.

Source files
------------

// File: rtl/fill_pkg.sv
// fill_pkg: shared types and default resolution constants for the
// rectangle fill engine.
//   fill_state_t : controller states (IDLE, FILL, DONE)
//   *_DEF        : default screen size and coordinate widths
package fill_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int XW_DEF    = 10;
  localparam int YW_DEF    = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/span_counter.sv
// span_counter: loadable up-counter with enable and terminal flag.
// Ports:
//   clk, reset : clock, async active-high reset (count -> 0)
//   load       : load load_val (takes priority over en)
//   load_val   : value loaded on load
//   en         : count up by one; holds once count reaches limit
//   limit      : terminal value
//   count      : current value
//   term       : count == limit
module span_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         term
);

  logic [W-1:0] count_q, count_d;

  assign term  = (count_q == limit);
  assign count = count_q;

  // Saturating at limit keeps the counter from ever running past the span.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && !term) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rect_fill.sv
// rect_fill: walks an axis-aligned rectangle column-major (y inner, x outer)
// and presents one pixel per accepted write on a valid/ready style sink.
// Ports:
//   clk, reset          : clock, async active-high reset
//   start               : request, sampled only in IDLE
//   x0, x1, y0, y1      : inclusive bounds, clamped to the screen on capture
//   fill_color          : colour captured with the bounds
//   wr_ready            : sink takes the current pixel this cycle
//   x, y, color, wr_en  : current pixel and its valid
//   busy                : high while filling
//   done                : one-cycle completion pulse
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// FILL    | presenting pixels, advancing on wr_en & wr_ready
// DONE    | one-cycle done pulse, then back to IDLE
module rect_fill
  import fill_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] fill_color,
  input  logic          wr_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] color,
  output logic          wr_en,
  output logic          busy,
  output logic          done
);

  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  fill_state_t   state_q, state_d;
  logic [XW-1:0] x1_q, x1_d;
  logic [YW-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [CW-1:0] color_q, color_d;

  logic [XW-1:0] x0_c, x1_c;
  logic [YW-1:0] y0_c, y1_c;
  logic          empty;
  logic          start_go, accept, col_end;
  logic          x_term, y_term;
  logic          x_load, x_en, y_load, y_en;
  logic [YW-1:0] y_load_val;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  assign x0_c  = (x0 > X_MAX) ? X_MAX : x0;
  assign x1_c  = (x1 > X_MAX) ? X_MAX : x1;
  assign y0_c  = (y0 > Y_MAX) ? Y_MAX : y0;
  assign y1_c  = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty = (x0_c > x1_c) || (y0_c > y1_c);

  assign start_go = (state_q == ST_IDLE) && start;
  assign accept   = (state_q == ST_FILL) && wr_ready;
  // Column finished but more columns remain: step x, rewind y.
  assign col_end  = accept && y_term && !x_term;

  // Counters load straight from the clamped inputs so the first pixel is
  // valid the cycle after start; y rewinds from the captured y0.
  assign x_load     = start_go;
  assign x_en       = col_end;
  assign y_load     = start_go || col_end;
  assign y_load_val = start_go ? y0_c : y0_q;
  assign y_en       = accept && !y_term;

  span_counter #(.W(XW)) u_x_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (x_load),
    .load_val (x0_c),
    .en       (x_en),
    .limit    (x1_q),
    .count    (x_cnt),
    .term     (x_term)
  );

  span_counter #(.W(YW)) u_y_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (y_load),
    .load_val (y_load_val),
    .en       (y_en),
    .limit    (y1_q),
    .count    (y_cnt),
    .term     (y_term)
  );

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x1_d    = x1_c;
          y0_d    = y0_c;
          y1_d    = y1_c;
          color_d = fill_color;
          state_d = empty ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept && x_term && y_term) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
    end
  end

  assign x     = x_cnt;
  assign y     = y_cnt;
  assign color = color_q;
  assign wr_en = (state_q == ST_FILL);
  assign busy  = (state_q == ST_FILL);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: self-checking bench for rect_fill on a 6x4 screen.
// A reference list of expected pixels is built with nested loops from the
// clamped bounds; the DUT's accepted writes are matched against it in order.
module tb_rect_fill;

  localparam int H  = 6;
  localparam int V  = 4;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0, x1, x;
  logic [YW-1:0] y0, y1, y;
  logic [CW-1:0] fill_color, color;
  logic          wr_ready, wr_en, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int qx[$];
  int qy[$];

  rect_fill #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .fill_color (fill_color),
    .wr_ready   (wr_ready),
    .x          (x),
    .y          (y),
    .color      (color),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: wr_ready always high; 1: random; 2: hold wr_ready low for three
  // cycles the first time pixel (sx,sy) is presented.
  task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                          input int col, input int mode, input int sx, input int sy,
                          input bit restart, input int abort_at);
    int cx0, cx1, cy0, cy1, n, cyc, limit;
    int acc, refused, busy_cnt, done_cyc, last_acc, stall_left, max_x;
    bit rdy;
    cx0 = (ax0 > H - 1) ? H - 1 : ax0;
    cx1 = (ax1 > H - 1) ? H - 1 : ax1;
    cy0 = (ay0 > V - 1) ? V - 1 : ay0;
    cy1 = (ay1 > V - 1) ? V - 1 : ay1;
    qx.delete();
    qy.delete();
    for (int i = cx0; i <= cx1; i++)
      for (int j = cy0; j <= cy1; j++) begin
        qx.push_back(i);
        qy.push_back(j);
      end
    n = qx.size();

    @(negedge clk);
    x0 = XW'(ax0); x1 = XW'(ax1);
    y0 = YW'(ay0); y1 = YW'(ay1);
    fill_color = CW'(col);
    wr_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    cyc = 1; acc = 0; refused = 0; busy_cnt = 0; done_cyc = 0;
    last_acc = 0; stall_left = 3; max_x = 0; limit = 8 * n + 20;
    while (done_cyc == 0 && cyc <= limit) begin
      if (cyc == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_color", color, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        wr_ready = 1'b1;
        return;
      end
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (int'(x) > max_x) max_x = int'(x);
        if (qx.size() == 0) begin
          check("extra_write", wr_en, 0);
        end else begin
          check("px_x", x, qx[0]);
          check("px_y", y, qy[0]);
          check("px_color", color, col);
        end
        check("busy_in_fill", busy, 1);
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        else if (int'(x) == sx && int'(y) == sy && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else rdy = 1'b1;
        wr_ready = rdy;
        if (rdy) begin
          acc++;
          last_acc = cyc;
          if (qx.size() > 0) begin
            void'(qx.pop_front());
            void'(qy.pop_front());
          end
        end else refused++;
      end else if (done) begin
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end else begin
        check("wr_en_or_done", wr_en | done, 1);
      end
      if (restart && cyc == 2) begin
        x0 = XW'($urandom_range(0, 15));
        x1 = XW'($urandom_range(0, 15));
        y0 = YW'($urandom_range(0, 7));
        y1 = YW'($urandom_range(0, 7));
        fill_color = CW'($urandom_range(0, 3));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end

    check("done_seen", done_cyc != 0, 1);
    check("write_count", acc, n);
    check("done_latency", done_cyc, (n == 0) ? 1 : last_acc + 1);
    check("busy_cycles", busy_cnt, n + refused);
    check("x_within_res", max_x <= H - 1, 1);
    if (mode == 0) check("done_cycle", done_cyc, n + 1);
    if (mode == 2) begin
      check("stall_cycles", refused, 3);
      check("done_cycle_stalled", done_cyc, n + 4);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_no_wr", wr_en, 0);
    wr_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wr_ready = 1'b1;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    fill_color = '0;
    #3;
    check("init_x", x, 0);
    check("init_y", y, 0);
    check("init_color", color, 0);
    check("init_wr_en", wr_en, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    run_fill(0, 5, 0, 3, 1, 0, 0, 0, 1'b0, 0);    // full screen
    run_fill(2, 3, 1, 2, 1, 0, 0, 0, 1'b0, 0);    // small region
    run_fill(2, 3, 1, 2, 1, 2, 2, 2, 1'b0, 0);    // back-pressure at (2,2)
    run_fill(4, 2, 0, 3, 2, 0, 0, 0, 1'b0, 0);    // empty region
    run_fill(0, 5, 0, 3, 3, 0, 0, 0, 1'b0, 7);    // reset mid-fill
    run_fill(1, 4, 0, 2, 2, 1, 0, 0, 1'b0, 0);    // start right after reset
    run_fill(0, 9, 0, 3, 1, 0, 0, 0, 1'b1, 0);    // restart ignored, x clamps
    run_fill(3, 9, 2, 7, 2, 1, 0, 0, 1'b0, 0);    // both axes clamp
    run_fill(12, 14, 5, 6, 3, 0, 0, 0, 1'b0, 0);  // single clamped pixel

    for (int k = 0; k < 25; k++) begin
      run_fill($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3), 1, 0, 0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
